// File: rtl/blink_sequencer.sv
// Front-panel LED sequencer: debounces two active-low buttons and steps one of three
// LED patterns at a programmable tick rate under an IDLE/RUN/PAUSE state machine.
module blink_sequencer #(
    parameter int TICK_CYCLES     = 13500000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LED_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button_0,
    input  logic             button_1,
    output logic [LED_W-1:0] led,
    output logic             running,
    output logic [1:0]       mode
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          w_raw;
    logic [1:0]          w_press;
    logic [1:0]          r_mode;
    logic [LED_W-1:0]    r_pattern;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick_wrap;

    function automatic logic [LED_W-1:0] f_init(input logic [1:0] m);
        f_init = (m == 2'd1) ? LED_W'(1) : '0;
    endfunction

    function automatic logic [LED_W-1:0] f_step(input logic [1:0] m, input logic [LED_W-1:0] p);
        case (m)
            2'd0:    f_step = p + LED_W'(1);
            2'd1:    f_step = {p[LED_W-2:0], p[LED_W-1]};
            default: f_step = ~p;
        endcase
    endfunction

    assign w_raw = {button_1, button_0};

    // Per button: 2-flop sync, stability counter, then a registered falling-edge pulse.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_deb_d;
        logic            r_press;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_deb   <= 1'b1;
                r_deb_d <= 1'b1;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                r_press <= r_deb_d & ~r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stop / mode-select on button 1 always takes priority over button 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_press[1] && w_press[0]) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_press[1])      w_state_nxt = S_IDLE;
                else if (w_press[0]) w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_press[1])      w_state_nxt = S_IDLE;
                else if (w_press[0]) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        led     = '1;
        running = 1'b0;
        if (r_state == S_RUN)   running = 1'b1;
        if (r_state != S_IDLE)  led = ~r_pattern;
    end

    assign mode        = r_mode;
    assign w_tick_wrap = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));

    // RUN keeps counting on the edge that pauses, so a coinciding step is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 2'd0;
            r_pattern  <= '0;
            r_tick_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press[1]) begin
                        r_mode <= (r_mode == 2'd2) ? 2'd0 : r_mode + 2'd1;
                    end else if (w_press[0]) begin
                        r_pattern  <= f_init(r_mode);
                        r_tick_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_press[1]) begin
                        r_pattern  <= '0;
                        r_tick_cnt <= '0;
                    end else if (w_tick_wrap) begin
                        r_tick_cnt <= '0;
                        r_pattern  <= f_step(r_mode, r_pattern);
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (w_press[1]) begin
                        r_pattern  <= '0;
                        r_tick_cnt <= '0;
                    end
                end
                default: begin
                    r_pattern  <= '0;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer: every output change is popped from an expected queue.
module tb_blink_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_0 = 1'b1;
    logic       button_1 = 1'b1;
    logic [2:0] led;
    logic       running;
    logic [1:0] mode;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] led;
        logic       run;
        logic [1:0] mode;
        int         at;
    } exp_t;

    exp_t q[$];

    blink_sequencer #(
        .TICK_CYCLES    (8),
        .DEBOUNCE_CYCLES(4),
        .LED_W          (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button_0(button_0),
        .button_1(button_1),
        .led     (led),
        .running (running),
        .mode    (mode)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic hold(input logic [1:0] m, input int n);
        if (m[0]) button_0 = 1'b0;
        if (m[1]) button_1 = 1'b0;
        repeat (n) tick();
        button_0 = 1'b1;
        button_1 = 1'b1;
    endtask

    task automatic expect_out(input logic [2:0] l, input logic r, input logic [1:0] m, input int at);
        exp_t e;
        e.led  = l;
        e.run  = r;
        e.mode = m;
        e.at   = at;
        q.push_back(e);
    endtask

    // Monitor: any change of {led, running, mode} is one output event.
    initial begin
        logic [5:0] prev;
        logic [5:0] now;
        exp_t       e;
        int         n;
        prev = 'x;
        n = 0;
        forever begin
            @(negedge clk);
            now = {led, running, mode};
            if (now !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event ev%0d got led=%b run=%b mode=%0d @%0d required no change",
                             n, led, running, mode, cyc);
                end else begin
                    e = q.pop_front();
                    if (led !== e.led || running !== e.run || mode !== e.mode || cyc != e.at) begin
                        errors++;
                        $display("FAIL event%0d got led=%b run=%b mode=%0d @%0d required led=%b run=%b mode=%0d @%0d",
                                 n, led, running, mode, cyc, e.led, e.run, e.mode, e.at);
                    end
                end
                n++;
                prev = now;
            end
        end
    end

    initial begin
        int c, r, b;
        logic [2:0] bin_led [9];
        bin_led = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000, 3'b111, 3'b110};

        // Reset state, with button_0 already held low before reset releases.
        expect_out(3'b111, 1'b0, 2'd0, 1);
        idle(2);
        button_0 = 1'b0;
        tick();
        rst = 1'b0;
        c = cyc;
        expect_out(3'b111, 1'b1, 2'd0, c + 8);
        for (int k = 0; k < 9; k++) expect_out(bin_led[k], 1'b1, 2'd0, c + 16 + 8 * k);
        expect_out(3'b111, 1'b0, 2'd0, c + 81);
        idle(10);
        button_0 = 1'b1;
        wait_to(c + 73);
        hold(2'b10, 6);
        idle(20);

        // Bouncing press is rejected, then a clean press starts RUN; pause at count 5.
        button_0 = 1'b0; idle(3);
        button_0 = 1'b1; idle(1);
        button_0 = 1'b0; idle(3);
        button_0 = 1'b1; idle(20);
        c = cyc;
        r = c + 8;
        expect_out(3'b111, 1'b1, 2'd0, r);
        expect_out(3'b110, 1'b1, 2'd0, r + 8);
        expect_out(3'b101, 1'b1, 2'd0, r + 16);
        expect_out(3'b101, 1'b0, 2'd0, r + 21);
        hold(2'b01, 6);
        wait_to(r + 13);
        hold(2'b01, 6);

        // Resume after 50 frozen cycles, pause again, then stop from PAUSE.
        b = r + 71;
        wait_to(b - 8);
        expect_out(3'b101, 1'b1, 2'd0, b);
        expect_out(3'b100, 1'b1, 2'd0, b + 3);
        expect_out(3'b011, 1'b1, 2'd0, b + 11);
        expect_out(3'b011, 1'b0, 2'd0, b + 14);
        expect_out(3'b111, 1'b0, 2'd0, b + 32);
        hold(2'b01, 6);
        wait_to(b + 6);
        hold(2'b01, 6);
        wait_to(b + 24);
        hold(2'b10, 6);
        idle(20);

        // Both buttons together at pattern 3: stop wins.
        c = cyc;
        r = c + 8;
        expect_out(3'b111, 1'b1, 2'd0, r);
        expect_out(3'b110, 1'b1, 2'd0, r + 8);
        expect_out(3'b101, 1'b1, 2'd0, r + 16);
        expect_out(3'b100, 1'b1, 2'd0, r + 24);
        expect_out(3'b111, 1'b0, 2'd0, r + 28);
        hold(2'b01, 6);
        wait_to(r + 20);
        hold(2'b11, 6);
        idle(20);

        // Chase mode.
        c = cyc;
        expect_out(3'b111, 1'b0, 2'd1, c + 8);
        hold(2'b10, 6);
        idle(14);
        c = cyc;
        r = c + 8;
        expect_out(3'b110, 1'b1, 2'd1, r);
        expect_out(3'b101, 1'b1, 2'd1, r + 8);
        expect_out(3'b011, 1'b1, 2'd1, r + 16);
        expect_out(3'b110, 1'b1, 2'd1, r + 24);
        expect_out(3'b101, 1'b1, 2'd1, r + 32);
        expect_out(3'b111, 1'b0, 2'd1, r + 33);
        hold(2'b01, 6);
        wait_to(r + 25);
        hold(2'b10, 6);
        idle(20);

        // Mode select wraps 2 -> 0, never 3; end at mode 2.
        c = cyc; expect_out(3'b111, 1'b0, 2'd2, c + 8); hold(2'b10, 6); idle(10);
        c = cyc; expect_out(3'b111, 1'b0, 2'd0, c + 8); hold(2'b10, 6); idle(10);
        c = cyc; expect_out(3'b111, 1'b0, 2'd1, c + 8); hold(2'b10, 6); idle(10);
        c = cyc; expect_out(3'b111, 1'b0, 2'd2, c + 8); hold(2'b10, 6); idle(10);

        // Toggle mode, then a one-cycle reset mid-RUN.
        c = cyc;
        r = c + 8;
        expect_out(3'b111, 1'b1, 2'd2, r);
        expect_out(3'b000, 1'b1, 2'd2, r + 8);
        expect_out(3'b111, 1'b0, 2'd0, r + 10);
        hold(2'b01, 6);
        wait_to(r + 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(40);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d left required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
